status_pulse_gen: RTL and testbench

- Parametrised, multi-channel converter from HPS OSD status bits to clean, timed control pulses for the core.
- Covers trigger items (coin, start, reset) and level items (e.g. aspect ratio).
- Sits between hps_io status/joystick outputs and target_top inputs.
- Per channel it synchronises, edge-detects, stretches to a fixed width, enforces a minimum low gap, queues one pending request, and ORs in a player button.

---
 rtl/status_pulse_gen.sv | 185 ++++++++++++++++++
 tb/tb_status_pulse_gen.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/status_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : status_pulse_gen
// Purpose  : Converts OSD status bits from hps_io into clean, timed control
//            pulses for the core. Each channel synchronises its status bit,
//            detects rising edges, stretches them to a fixed width, enforces a
//            minimum low gap, queues one pending request and ORs in a player
//            button. Channels flagged in LEVEL_MASK pass the synchronised level
//            straight through instead.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            status_in  - raw status bits, asynchronous to clk
//            button_in  - active-high button levels, synchronous to clk
//            pulse_out  - registered control outputs
//            busy       - channel is pulsing, in its gap, or has a request queued
// Revision : 1.0 - initial release
// ============================================================================
module status_pulse_gen #(
    parameter int                  CHANNELS     = 4,
    parameter int                  PULSE_CYCLES = 50000,
    parameter int                  GAP_CYCLES   = 25000,
    parameter int                  SYNC_STAGES  = 2,
    parameter int                  RETRIGGER    = 0,
    parameter logic [CHANNELS-1:0] LEVEL_MASK   = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] status_in,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] pulse_out,
    output logic [CHANNELS-1:0] busy
);

    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // The arm counter waits until prev_q holds a value that was sampled after
    // reset release, so a status bit already high at release reads as steady.
    localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0]                  sync_last;
    logic [CHANNELS-1:0]                  prev_q;
    logic [CHANNELS-1:0]                  button_q;
    logic [ARM_W-1:0]                     arm_q;
    logic                                 armed;
    logic [CHANNELS-1:0]                  pulse_q;
    logic [CHANNELS-1:0]                  pulse_d;
    logic [CHANNELS-1:0]                  busy_q;
    logic [CHANNELS-1:0]                  busy_d;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign armed     = (arm_q == ARM_DONE);

    // ------------------------------------------------------------------------
    // Shared input stage and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            prev_q   <= '0;
            button_q <= '0;
            arm_q    <= '0;
            pulse_q  <= '0;
            busy_q   <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], status_in};
            prev_q   <= sync_last;
            button_q <= button_in;
            if (!armed) begin
                arm_q <= arm_q + 1'b1;
            end
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;

    // ------------------------------------------------------------------------
    // Per-channel logic
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        if (LEVEL_MASK[i]) begin : g_level
            // prev_q is the synchronised level delayed one cycle, which gives
            // level channels the same input-to-output latency as pulse channels.
            assign pulse_d[i] = prev_q[i] | button_q[i];
            assign busy_d[i]  = 1'b0;
        end else begin : g_trig
            state_t           state_q;
            state_t           state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             pending_q;
            logic             pending_d;
            logic             trig;

            assign trig = armed & sync_last[i] & ~prev_q[i];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    pending_q <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    cnt_q     <= cnt_d;
                    pending_q <= pending_d;
                end
            end

            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                pending_d = pending_q;
                unique case (state_q)
                    ST_IDLE: begin
                        if (trig) begin
                            state_d = ST_ACTIVE;
                            cnt_d   = PULSE_LOAD;
                        end
                    end
                    ST_ACTIVE: begin
                        if ((RETRIGGER != 0) && trig) begin
                            cnt_d = PULSE_LOAD;
                        end else begin
                            // A trigger on the terminal cycle is folded into
                            // pending first so it is served without loss.
                            pending_d = pending_q | trig;
                            if (cnt_q == '0) begin
                                if (GAP_CYCLES > 0) begin
                                    state_d = ST_GAP;
                                    cnt_d   = GAP_LOAD;
                                end else if (pending_d) begin
                                    cnt_d     = PULSE_LOAD;
                                    pending_d = 1'b0;
                                end else begin
                                    state_d = ST_IDLE;
                                end
                            end else begin
                                cnt_d = cnt_q - 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        pending_d = pending_q | trig;
                        if (cnt_q == '0) begin
                            if (pending_d) begin
                                state_d   = ST_ACTIVE;
                                cnt_d     = PULSE_LOAD;
                                pending_d = 1'b0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        pending_d = 1'b0;
                    end
                endcase
            end

            // pending can only be set outside IDLE and is consumed on the way
            // back to ACTIVE, so "not IDLE" already covers a queued request.
            assign pulse_d[i] = (state_q == ST_ACTIVE) | button_q[i];
            assign busy_d[i]  = (state_q != ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_status_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_status_pulse_gen
// Purpose  : Self-checking bench for status_pulse_gen. Three instances share
//            the same stimulus: queued mode with gap, retrigger mode with gap,
//            and queued mode without gap. Channel 3 is a level channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_status_pulse_gen;

    localparam int         P    = 8;
    localparam logic [3:0] LVL  = 4'b1000;
    localparam int         ND   = 3;
    localparam int         GAPS [ND] = '{4, 4, 0};
    localparam int         RETR [ND] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] status_in;
    logic [3:0] button_in;
    logic [3:0] p0, p1, p2, b0, b1, b2;

    always #5 clk = ~clk;

    status_pulse_gen #(.CHANNELS(4), .PULSE_CYCLES(P), .GAP_CYCLES(4), .SYNC_STAGES(2),
                       .RETRIGGER(0), .LEVEL_MASK(LVL)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .status_in(status_in), .button_in(button_in),
        .pulse_out(p0), .busy(b0));

    status_pulse_gen #(.CHANNELS(4), .PULSE_CYCLES(P), .GAP_CYCLES(4), .SYNC_STAGES(2),
                       .RETRIGGER(1), .LEVEL_MASK(LVL)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .status_in(status_in), .button_in(button_in),
        .pulse_out(p1), .busy(b1));

    status_pulse_gen #(.CHANNELS(4), .PULSE_CYCLES(P), .GAP_CYCLES(0), .SYNC_STAGES(2),
                       .RETRIGGER(0), .LEVEL_MASK(LVL)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .status_in(status_in), .button_in(button_in),
        .pulse_out(p2), .busy(b2));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: history of sampled inputs plus remaining-time counts.
    logic [3:0] sq[$];
    logic [3:0] bq[$];
    int         act_left [ND][4];
    int         gap_left [ND][4];
    bit         pend     [ND][4];
    logic [3:0] exp_p    [ND];
    logic [3:0] exp_b    [ND];

    typedef struct {
        int         cyc;
        logic [3:0] st;
        logic [3:0] bt;
        logic [3:0] ep;
        logic [3:0] eb;
    } vec_t;

    localparam int NT = 44;
    vec_t tbl [NT];

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [3:0] dut_p(input int d);
        case (d)
            0:       return p0;
            1:       return p1;
            default: return p2;
        endcase
    endfunction

    function automatic logic [3:0] dut_b(input int d);
        case (d)
            0:       return b0;
            1:       return b1;
            default: return b2;
        endcase
    endfunction

    task automatic model_reset();
        sq.delete();
        bq.delete();
        for (int d = 0; d < ND; d++) begin
            exp_p[d] = 4'b0;
            exp_b[d] = 4'b0;
            for (int ch = 0; ch < 4; ch++) begin
                act_left[d][ch] = 0;
                gap_left[d][ch] = 0;
                pend[d][ch]     = 1'b0;
            end
        end
    endtask

    // Predicts the outputs after the coming clock edge, which samples st/bt.
    // Sample index k = edges since reset release. A rising edge counts when
    // the input was 1 at sample k-2 and 0 at sample k-3 (both after release).
    task automatic model_edge(input logic [3:0] st, input logic [3:0] bt);
        int         k;
        logic [3:0] bprev, s2, s3;
        bit         trig;
        k     = sq.size();
        bprev = (k >= 1) ? bq[k-1] : 4'b0;
        s2    = (k >= 2) ? sq[k-2] : 4'b0;
        s3    = (k >= 3) ? sq[k-3] : 4'b0;
        for (int d = 0; d < ND; d++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (LVL[ch]) begin
                    exp_p[d][ch] = s3[ch] | bprev[ch];
                    exp_b[d][ch] = 1'b0;
                end else begin
                    exp_p[d][ch] = (act_left[d][ch] > 0) || bprev[ch];
                    exp_b[d][ch] = (act_left[d][ch] > 0) || (gap_left[d][ch] > 0);
                    trig = (k >= 3) && s2[ch] && !s3[ch];
                    if (act_left[d][ch] > 0) begin
                        if (RETR[d] != 0 && trig) begin
                            act_left[d][ch] = P;
                        end else begin
                            if (trig) pend[d][ch] = 1'b1;
                            act_left[d][ch]--;
                            if (act_left[d][ch] == 0) begin
                                if (GAPS[d] > 0) begin
                                    gap_left[d][ch] = GAPS[d];
                                end else if (pend[d][ch]) begin
                                    act_left[d][ch] = P;
                                    pend[d][ch]     = 1'b0;
                                end
                            end
                        end
                    end else if (gap_left[d][ch] > 0) begin
                        if (trig) pend[d][ch] = 1'b1;
                        gap_left[d][ch]--;
                        if (gap_left[d][ch] == 0 && pend[d][ch]) begin
                            act_left[d][ch] = P;
                            pend[d][ch]     = 1'b0;
                        end
                    end else if (trig) begin
                        act_left[d][ch] = P;
                    end
                end
            end
        end
        sq.push_back(st);
        bq.push_back(bt);
    endtask

    task automatic model_check();
        for (int d = 0; d < ND; d++) begin
            check($sformatf("model pulse dut%0d", d), dut_p(d), exp_p[d]);
            check($sformatf("model busy dut%0d", d), dut_b(d), exp_b[d]);
        end
    endtask

    // Called right after a falling edge; the next rising edge samples st/bt.
    task automatic drive(input logic [3:0] st, input logic [3:0] bt);
        status_in = st;
        button_in = bt;
        if (rst_n) model_edge(st, bt);
    endtask

    initial begin
        logic [3:0] cur_s, cur_b, rs, rb;
        int         ti;

        // cyc: falling edge at which outputs are checked, then inputs applied
        tbl[0]  = '{0,   4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{10,  4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{13,  4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{14,  4'b0000, 4'b0000, 4'b0001, 4'b0001};
        tbl[4]  = '{21,  4'b0000, 4'b0000, 4'b0001, 4'b0001};
        tbl[5]  = '{22,  4'b0000, 4'b0000, 4'b0000, 4'b0001};
        tbl[6]  = '{25,  4'b0000, 4'b0000, 4'b0000, 4'b0001};
        tbl[7]  = '{26,  4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{30,  4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[9]  = '{31,  4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[10] = '{32,  4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tbl[11] = '{33,  4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[12] = '{40,  4'b1000, 4'b0000, 4'b0000, 4'b0000};
        tbl[13] = '{43,  4'b1000, 4'b0000, 4'b0000, 4'b0000};
        tbl[14] = '{44,  4'b1000, 4'b0000, 4'b1000, 4'b0000};
        tbl[15] = '{50,  4'b0000, 4'b0000, 4'b1000, 4'b0000};
        tbl[16] = '{53,  4'b0000, 4'b0000, 4'b1000, 4'b0000};
        tbl[17] = '{54,  4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[18] = '{60,  4'b1111, 4'b0000, 4'b0000, 4'b0000};
        tbl[19] = '{63,  4'b1111, 4'b0000, 4'b0000, 4'b0000};
        tbl[20] = '{64,  4'b1111, 4'b0000, 4'b1111, 4'b0111};
        tbl[21] = '{70,  4'b0000, 4'b0000, 4'b1111, 4'b0111};
        tbl[22] = '{71,  4'b0000, 4'b0000, 4'b1111, 4'b0111};
        tbl[23] = '{72,  4'b0000, 4'b0000, 4'b1000, 4'b0111};
        tbl[24] = '{74,  4'b0000, 4'b0000, 4'b0000, 4'b0111};
        tbl[25] = '{75,  4'b0000, 4'b0000, 4'b0000, 4'b0111};
        tbl[26] = '{76,  4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[27] = '{80,  4'b0010, 4'b0000, 4'b0000, 4'b0000};
        tbl[28] = '{82,  4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[29] = '{85,  4'b0010, 4'b0000, 4'b0010, 4'b0010};
        tbl[30] = '{86,  4'b0000, 4'b0000, 4'b0010, 4'b0010};
        tbl[31] = '{87,  4'b0010, 4'b0000, 4'b0010, 4'b0010};
        tbl[32] = '{91,  4'b0010, 4'b0000, 4'b0010, 4'b0010};
        tbl[33] = '{92,  4'b0010, 4'b0000, 4'b0000, 4'b0010};
        tbl[34] = '{95,  4'b0000, 4'b0000, 4'b0000, 4'b0010};
        tbl[35] = '{96,  4'b0000, 4'b0000, 4'b0010, 4'b0010};
        tbl[36] = '{103, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
        tbl[37] = '{104, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
        tbl[38] = '{107, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
        tbl[39] = '{108, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[40] = '{110, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[41] = '{111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[42] = '{112, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[43] = '{113, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        rst_n     = 1'b0;
        status_in = 4'b0;
        button_in = 4'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("in reset pulse", p0, 4'b0);
            check("in reset busy", b0, 4'b0);
            drive(4'b0, 4'b0);
        end

        // ---------------- table-driven directed timeline ----------------
        cur_s = 4'b0;
        cur_b = 4'b0;
        ti    = 0;
        for (int c = 0; c <= 113; c++) begin
            @(negedge clk);
            model_check();
            if (c == 0) rst_n = 1'b1;
            if (ti < NT && tbl[ti].cyc == c) begin
                check($sformatf("table c%0d pulse", c), p0, tbl[ti].ep);
                check($sformatf("table c%0d busy", c), b0, tbl[ti].eb);
                cur_s = tbl[ti].st;
                cur_b = tbl[ti].bt;
                ti++;
            end
            drive(cur_s, cur_b);
        end

        // ---------------- status already high through reset release ----------------
        @(negedge clk);
        model_check();
        rst_n = 1'b0;
        model_reset();
        drive(4'b0111, 4'b0);
        repeat (2) begin
            @(negedge clk);
            model_check();
            drive(4'b0111, 4'b0);
        end
        @(negedge clk);
        model_check();
        rst_n = 1'b1;
        drive(4'b0111, 4'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            model_check();
            check("held at release pulse", p0, 4'b0);
            check("held at release busy", b0, 4'b0);
            drive(4'b0111, 4'b0);
        end
        repeat (4) begin
            @(negedge clk);
            model_check();
            drive(4'b0, 4'b0);
        end

        // ---------------- asynchronous reset in the middle of a pulse ----------------
        @(negedge clk);
        model_check();
        drive(4'b0001, 4'b0);
        repeat (6) begin
            @(negedge clk);
            model_check();
            drive(4'b0000, 4'b0);
        end
        check("mid pulse before reset", p0, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("async reset pulse", p0, 4'b0);
        check("async reset busy", b0, 4'b0);
        check("async reset pulse dut1", p1, 4'b0);
        model_reset();
        repeat (2) begin
            @(negedge clk);
            model_check();
            drive(4'b0, 4'b0);
        end
        @(negedge clk);
        model_check();
        rst_n = 1'b1;
        drive(4'b0, 4'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            model_check();
            check("after reset pulse", p0, 4'b0);
            check("after reset busy", b0, 4'b0);
            drive(4'b0, 4'b0);
        end

        // ---------------- randomized stimulus against the model ----------------
        rs = 4'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            model_check();
            for (int ch = 0; ch < 4; ch++) begin
                // Slow toggling first, then fast toggling to hit queue,
                // discard, retrigger and terminal-cycle coincidences.
                if ($urandom_range((c < 2500) ? 11 : 2) == 0) rs[ch] = ~rs[ch];
                rb[ch] = ($urandom_range(15) == 0);
            end
            drive(rs, rb);
        end
        @(negedge clk);
        model_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
